sobel_bit_packer: RTL and testbench

Downstream stage of the Sobel pipeline. Consumes the 8-bit edge-magnitude stream (`valid_i`/`pixel_i`, no backpressure) and thresholds each pixel to one bit. Packs eight bits per byte and buffers the bytes in a small FIFO. Presents them on a valid/ready byte stream toward the UART/host interface, with a last-byte marker per frame.

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_bit_packer_if.sv | 10 +
 rtl/fifo_1r1w_sync.sv | 71 +++++++
 rtl/sobel_bit_packer.sv | 101 ++++++++++
 tb/tb_sobel_bit_packer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel bit-packer stage. bytes_per_frame follows
// SOBEL_PACK_ROW_PAD_EN the same way the packer does.
package sobel_pkg;

    typedef enum logic {
        COLLECT_S,
        DONE_S
    } state_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } byte_entry_t;

    localparam int BYTE_ENTRY_W = $bits(byte_entry_t);

    function automatic int bytes_per_frame(input int width, input int height);
`ifdef SOBEL_PACK_ROW_PAD_EN
        return height * ((width + 7) / 8);
`else
        return (width * height + 7) / 8;
`endif
    endfunction

endpackage

// File: rtl/sobel_bit_packer_if.sv
// Valid/ready byte stream from the packer toward the UART/host side.
interface sobel_bit_packer_if;
    logic       valid_o;
    logic [7:0] data_o;
    logic       last_o;
    logic       ready_i;

    modport master (output valid_o, data_o, last_o, input ready_i);
    modport slave  (input valid_o, data_o, last_o, output ready_i);
endinterface

// File: rtl/fifo_1r1w_sync.sv
// Single-clock first-word-fall-through FIFO; head word, full and empty are
// all registers so nothing downstream sees a combinational path.
module fifo_1r1w_sync #(
    parameter int WIDTH_P = 9,
    parameter int DEPTH_P = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [WIDTH_P-1:0] push_data_i,
    input  logic               pop_i,
    output logic [WIDTH_P-1:0] head_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int              AW         = $clog2(DEPTH_P);
    localparam logic [AW:0]     ONE_COUNT  = (AW + 1)'(1);
    localparam logic [AW:0]     FULL_COUNT = (AW + 1)'(DEPTH_P);

    logic [WIDTH_P-1:0] mem [DEPTH_P];
    logic [AW-1:0]      wr_ptr_r, rd_ptr_r, rd_ptr_inc;
    logic [AW:0]        count_r, count_next;
    logic [WIDTH_P-1:0] head_next;
    logic               pop, push_ok;

    assign pop        = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok    = push_i & (~full_o | pop);
    assign rd_ptr_inc = rd_ptr_r + 1'b1;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        count_next = count_r;
        head_next  = head_o;
        if (push_ok && !pop)
            count_next = count_r + 1'b1;
        else if (!push_ok && pop)
            count_next = count_r - 1'b1;

        if (pop)
            head_next = (push_ok && count_r == ONE_COUNT) ? push_data_i : mem[rd_ptr_inc];
        else if (push_ok && empty_o)
            head_next = push_data_i;
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_o   <= '0;
            full_o   <= 1'b0;
            empty_o  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop)     rd_ptr_r <= rd_ptr_inc;
            count_r <= count_next;
            head_o  <= head_next;
            full_o  <= (count_next == FULL_COUNT);
            empty_o <= (count_next == '0);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_r] <= push_data_i;
    end

endmodule

// File: rtl/sobel_bit_packer.sv
// Thresholds Sobel magnitudes to bits, packs eight per byte (earliest in bit 0)
// and queues bytes for the host. SOBEL_PACK_ROW_PAD_EN pads every row to a byte.
module sobel_bit_packer
    import sobel_pkg::*;
#(
    parameter int WIDTH_P      = 10,
    parameter int HEIGHT_P     = 10,
    parameter int FIFO_DEPTH_P = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      valid_i,
    input  logic [7:0]                pixel_i,
    input  logic [7:0]                threshold_i,
    sobel_bit_packer_if.master        byte_bus,
    output logic                      overflow_o,
    output logic                      done_o
);

    localparam int               COL_W    = (WIDTH_P > 1) ? $clog2(WIDTH_P) : 1;
    localparam int               ROW_W    = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH_P - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT_P - 1);

    state_t           state_r;
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       acc_r;

    logic        accept, pix_bit, last_col, frame_end, row_flush, emit, pop;
    logic        fifo_full, fifo_empty;
    logic [7:0]  packed_byte;
    byte_entry_t push_entry, head_entry;

    assign accept      = valid_i && (state_r == COLLECT_S);
    assign pix_bit     = (pixel_i >= threshold_i);
    assign last_col    = (col_r == COL_LAST);
    assign frame_end   = last_col && (row_r == ROW_LAST);
    assign packed_byte = acc_r | (8'(pix_bit) << bit_cnt_r);
`ifdef SOBEL_PACK_ROW_PAD_EN
    assign row_flush   = last_col;
`else
    assign row_flush   = 1'b0;
`endif
    // Coincident flush reasons still collapse to a single push.
    assign emit        = accept && ((bit_cnt_r == 3'd7) || frame_end || row_flush);
    assign push_entry  = '{last: frame_end, data: packed_byte};
    assign pop         = byte_bus.ready_i && !fifo_empty;

    fifo_1r1w_sync #(
        .WIDTH_P (BYTE_ENTRY_W),
        .DEPTH_P (FIFO_DEPTH_P)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (emit),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign byte_bus.valid_o = !fifo_empty;
    assign byte_bus.data_o  = head_entry.data;
    assign byte_bus.last_o  = head_entry.last;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= COLLECT_S;
            col_r      <= '0;
            row_r      <= '0;
            bit_cnt_r  <= '0;
            acc_r      <= '0;
            overflow_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            if (accept) begin
                if (last_col) begin
                    col_r <= '0;
                    row_r <= (row_r == ROW_LAST) ? '0 : row_r + 1'b1;
                end else begin
                    col_r <= col_r + 1'b1;
                end
                if (emit) begin
                    bit_cnt_r <= '0;
                    acc_r     <= '0;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 1'b1;
                    acc_r     <= packed_byte;
                end
                if (frame_end) state_r <= DONE_S;
            end
            // Dropped bytes still advance the counters; only the flag records them.
            if (emit && fifo_full && !pop) overflow_o <= 1'b1;
            done_o <= (state_r == DONE_S) && fifo_empty;
        end
    end

endmodule

// File: tb/tb_sobel_bit_packer.sv
// Directed bench for sobel_bit_packer; expectations follow SOBEL_PACK_ROW_PAD_EN.
module tb_sobel_bit_packer;
    import sobel_pkg::*;

    localparam int W    = 10;
    localparam int H    = 10;
    localparam int D    = 4;
    localparam int NPIX = W * H;
`ifdef SOBEL_PACK_ROW_PAD_EN
    localparam int FIFTH_PUSH = 27;
`else
    localparam int FIFTH_PUSH = 39;
`endif

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       valid_i = 1'b0;
    logic [7:0] pixel_i = 8'h00;
    logic [7:0] threshold_i = 8'h00;
    logic       overflow_o, done_o;

    sobel_bit_packer_if bus();

    sobel_bit_packer #(.WIDTH_P(W), .HEIGHT_P(H), .FIFO_DEPTH_P(D)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .valid_i     (valid_i),
        .pixel_i     (pixel_i),
        .threshold_i (threshold_i),
        .byte_bus    (bus),
        .overflow_o  (overflow_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (bus.valid_o && bus.ready_i && !reset_i) got_q.push_back({bus.last_o, bus.data_o});

    function automatic logic [8:0] got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 9'h1FF;
    endfunction

    function automatic logic [7:0] pix(input int mode, input int idx);
        case (mode)
            0:       return 8'h00;
            1:       return (idx % 2 == 0) ? 8'hFF : 8'h00;
            2:       return 8'h40;
            default: return 8'((idx * 37 + 11) % 256);
        endcase
    endfunction

    function automatic logic [7:0] thr_of(input int mode);
        case (mode)
            0:       return 8'h01;
            2:       return 8'h40;
            default: return 8'h80;
        endcase
    endfunction

    task automatic build_expected(input int mode);
        logic [7:0] b;
        logic [7:0] t;
        t = thr_of(mode);
        exp_q.delete();
`ifdef SOBEL_PACK_ROW_PAD_EN
        for (int r = 0; r < H; r++)
            for (int j = 0; j < (W + 7) / 8; j++) begin
                b = 8'h00;
                for (int k = 0; k < 8; k++)
                    if (j * 8 + k < W) b[k] = (pix(mode, r * W + j * 8 + k) >= t);
                exp_q.push_back({(r == H - 1) && (j == (W + 7) / 8 - 1), b});
            end
`else
        for (int j = 0; j < (NPIX + 7) / 8; j++) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++)
                if (j * 8 + k < NPIX) b[k] = (pix(mode, j * 8 + k) >= t);
            exp_q.push_back({j == (NPIX + 7) / 8 - 1, b});
        end
`endif
    endtask

    task automatic do_reset();
        reset_i     = 1'b1;
        valid_i     = 1'b0;
        pixel_i     = 8'h00;
        bus.ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        got_q.delete();
    endtask

    task automatic drive_frame(input int mode, input int ready_from, input bit ovf_check,
                               input int stop_at);
        threshold_i = thr_of(mode);
        for (int idx = 0; idx < stop_at; idx++) begin
            bus.ready_i = (idx >= ready_from);
            valid_i     = 1'b1;
            pixel_i     = pix(mode, idx);
            @(posedge clk);
            #1;
            if (ovf_check) begin
                if (idx == FIFTH_PUSH - 1) check("ovf_before_5th", overflow_o, 0);
                if (idx == FIFTH_PUSH)     check("ovf_on_5th", overflow_o, 1);
                if (idx == NPIX - 1)       check("ovf_sticky", overflow_o, 1);
            end
        end
        valid_i = 1'b0;
        pixel_i = 8'h00;
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 300 && !done_o; n++) begin
            @(posedge clk);
            #1;
        end
        check(tag, done_o, 1);
    endtask

    task automatic compare_frame(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), got_at(i), exp_q[i]);
        check({name, "_no_ovf"}, overflow_o, 0);
    endtask

    task automatic run_frame(input string name, input int mode, input int ready_from);
        do_reset();
        build_expected(mode);
        drive_frame(mode, ready_from, 1'b0, NPIX);
        wait_done({name, "_done"});
        compare_frame(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_valid", bus.valid_o, 0);
        check("rst_data", bus.data_o, 0);
        check("rst_last", bus.last_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_done", done_o, 0);

        run_frame("zero", 0, 0);
        check("zero_bpf", got_q.size(), bytes_per_frame(W, H));

        run_frame("alt", 1, 0);
        check("alt_first", got_at(0), 9'h055);
`ifdef SOBEL_PACK_ROW_PAD_EN
        check("alt_row_tail", got_at(1), 9'h001);
`else
        check("alt_final", got_at(12), 9'h105);
`endif

        run_frame("eq", 2, 0);
        check("eq_first", got_at(0), 9'h0FF);
`ifdef SOBEL_PACK_ROW_PAD_EN
        check("eq_row_tail", got_at(1), 9'h003);
`else
        check("eq_final", got_at(12), 9'h10F);
`endif

        // Consumer stalled for the whole frame: four bytes held, rest dropped.
        do_reset();
        build_expected(1);
        drive_frame(1, NPIX + 1, 1'b1, NPIX);
        check("stall_valid", bus.valid_o, 1);
        check("stall_not_done", done_o, 0);
        check("stall_none_taken", got_q.size(), 0);
        bus.ready_i = 1'b1;
        wait_done("stall_done");
        check("stall_count", got_q.size(), D);
        for (int i = 0; i < D; i++)
            check($sformatf("stall_byte%0d", i), got_at(i), {1'b0, exp_q[i][7:0]});
        check("stall_ovf_held", overflow_o, 1);

        // Pop opens exactly on the cycle the fifth byte is pushed into a full FIFO.
        run_frame("fullpp", 3, FIFTH_PUSH);

        // Asynchronous reset at col 5 row 3 with bytes still queued.
        do_reset();
        drive_frame(1, NPIX + 1, 1'b0, 3 * W + 5);
        check("mid_valid_before", bus.valid_o, 1);
        reset_i = 1'b1;
        #1;
        check("mid_rst_valid", bus.valid_o, 0);
        check("mid_rst_data", bus.data_o, 0);
        check("mid_rst_last", bus.last_o, 0);
        check("mid_rst_ovf", overflow_o, 0);
        @(posedge clk);
        #1 reset_i = 1'b0;
        got_q.delete();
        bus.ready_i = 1'b1;
        build_expected(2);
        drive_frame(2, 0, 1'b0, NPIX);
        wait_done("after_rst_done");
        compare_frame("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
